// File: rtl/data_bus_arbiter_pkg.sv
// Shared types for the data-memory port: master identifiers, lock counter width
// and the request bundle also used by the DMA block.
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        MST_NONE = 2'd0,
        MST_0    = 2'd1,
        MST_1    = 2'd2
    } master_id_t;

    localparam int DATA_BUS_LOCK_W = 8;
    localparam int DATA_BUS_ADDR_W = 32;
    localparam int DATA_BUS_DATA_W = 32;

    typedef struct packed {
        logic                         we;
        logic                         lock;
        logic [DATA_BUS_ADDR_W-1:0]   addr;
        logic [DATA_BUS_DATA_W-1:0]   wdata;
        logic [DATA_BUS_DATA_W/8-1:0] be;
    } data_bus_req_t;

    function automatic master_id_t master_of(input int idx);
        return (idx == 0) ? MST_0 : MST_1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way winner selection: a lone requester wins, a live lock holder keeps the
// port under contention, otherwise the master that did not win last goes next.
module rr_arbiter2
    import data_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] owner,
    input  logic       lock_expired,
    output logic [1:0] winner
);

    always_comb begin
        winner = MST_NONE;
        unique case (req)
            2'b01: winner = MST_0;
            2'b10: winner = MST_1;
            2'b11: begin
                if (owner != MST_NONE && !lock_expired) begin
                    winner = owner;
                end else begin
                    winner = last ? MST_0 : MST_1;
                end
            end
            default: winner = MST_NONE;
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master, one-slave arbiter for the shared data-memory port with round-robin
// fairness, a bounded lock for atomic sequences and one-cycle read return.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LOCK   = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_m0_req,
    input  logic                    i_m1_req,
    input  logic                    i_m0_we,
    input  logic                    i_m1_we,
    input  logic                    i_m0_lock,
    input  logic                    i_m1_lock,
    input  logic [ADDR_WIDTH-1:0]   i_m0_addr,
    input  logic [ADDR_WIDTH-1:0]   i_m1_addr,
    input  logic [DATA_WIDTH-1:0]   i_m0_wdata,
    input  logic [DATA_WIDTH-1:0]   i_m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_m0_be,
    input  logic [DATA_WIDTH/8-1:0] i_m1_be,
    output logic                    o_m0_gnt,
    output logic                    o_m1_gnt,
    output logic                    o_m0_rvalid,
    output logic                    o_m1_rvalid,
    output logic [DATA_WIDTH-1:0]   o_m0_rdata,
    output logic [DATA_WIDTH-1:0]   o_m1_rdata,
    output logic                    o_mem_we,
    output logic                    o_mem_re,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam logic [DATA_BUS_LOCK_W-1:0] LOCK_LIMIT = DATA_BUS_LOCK_W'(MAX_LOCK);

    logic                       last_q, last_next;
    master_id_t                 owner_q, owner_next;
    master_id_t                 rd_owner_q, rd_owner_next;
    logic [DATA_BUS_LOCK_W-1:0] lock_cnt_q, lock_cnt_next;

    logic [1:0] req_v;
    logic [1:0] gnt_v;
    logic [1:0] rvalid_v;
    logic [1:0] arb_winner;
    logic       lock_expired;
    master_id_t grant_id;
    logic       grant_we;
    logic       grant_lock;
    logic       other_req;

    assign req_v        = {i_m1_req, i_m0_req};
    assign lock_expired = (lock_cnt_q >= LOCK_LIMIT);

    rr_arbiter2 u_rr (
        .req          (req_v),
        .last         (last_q),
        .owner        (owner_q),
        .lock_expired (lock_expired),
        .winner       (arb_winner)
    );

    // Nothing is granted while reset is held, so every strobe stays low.
    assign grant_id = i_reset ? master_id_t'(arb_winner) : MST_NONE;

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign gnt_v[gi]    = (grant_id == master_of(gi));
        assign rvalid_v[gi] = (rd_owner_q == master_of(gi));
    end

    assign o_m0_gnt    = gnt_v[0];
    assign o_m1_gnt    = gnt_v[1];
    assign o_m0_rvalid = rvalid_v[0];
    assign o_m1_rvalid = rvalid_v[1];
    assign o_m0_rdata  = i_mem_rdata;
    assign o_m1_rdata  = i_mem_rdata;

    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;
        grant_we    = 1'b0;
        grant_lock  = 1'b0;
        other_req   = 1'b0;
        unique case (grant_id)
            MST_0: begin
                grant_we    = i_m0_we;
                grant_lock  = i_m0_lock;
                other_req   = i_m1_req;
                o_mem_addr  = i_m0_addr;
                o_mem_wdata = i_m0_wdata;
                o_mem_be    = i_m0_be;
            end
            MST_1: begin
                grant_we    = i_m1_we;
                grant_lock  = i_m1_lock;
                other_req   = i_m0_req;
                o_mem_addr  = i_m1_addr;
                o_mem_wdata = i_m1_wdata;
                o_mem_be    = i_m1_be;
            end
            default: ;
        endcase
        o_mem_we = (grant_id != MST_NONE) && grant_we;
        o_mem_re = (grant_id != MST_NONE) && !grant_we;
    end

    always_comb begin
        last_next     = last_q;
        owner_next    = owner_q;
        lock_cnt_next = lock_cnt_q;
        rd_owner_next = MST_NONE;

        if (grant_id != MST_NONE) begin
            last_next = (grant_id == MST_1);
            if (!grant_we) begin
                rd_owner_next = grant_id;
            end
        end

        // The counter only advances while the holder beats a live contender;
        // an uncontested lock therefore never runs out.
        if (owner_q == MST_NONE) begin
            if (grant_id != MST_NONE && grant_lock) begin
                owner_next = grant_id;
            end
        end else if (grant_id == owner_q && grant_lock) begin
            if (other_req && lock_cnt_q < LOCK_LIMIT) begin
                lock_cnt_next = lock_cnt_q + DATA_BUS_LOCK_W'(1);
            end
        end else begin
            owner_next    = MST_NONE;
            lock_cnt_next = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            last_q     <= 1'b1;
            owner_q    <= MST_NONE;
            lock_cnt_q <= '0;
            rd_owner_q <= MST_NONE;
        end else begin
            last_q     <= last_next;
            owner_q    <= owner_next;
            lock_cnt_q <= lock_cnt_next;
            rd_owner_q <= rd_owner_next;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed vector table, lock/reset sequences and
// randomized traffic against a behavioural model with its own memory image.
module tb_data_bus_arbiter;
    import data_bus_arbiter_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXL = 3;
    localparam int NV   = 19;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic [1:0]    t_req, t_we, t_lock;
    logic [AW-1:0] t_addr [2];
    logic [DW-1:0] t_wdata [2];
    logic [BW-1:0] t_be [2];

    logic          o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid;
    logic [DW-1:0] o_m0_rdata, o_m1_rdata;
    logic          o_mem_we, o_mem_re;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [BW-1:0] o_mem_be;
    logic [DW-1:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 i_clock = ~i_clock;

    data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(MAXL)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_m0_req    (t_req[0]),
        .i_m1_req    (t_req[1]),
        .i_m0_we     (t_we[0]),
        .i_m1_we     (t_we[1]),
        .i_m0_lock   (t_lock[0]),
        .i_m1_lock   (t_lock[1]),
        .i_m0_addr   (t_addr[0]),
        .i_m1_addr   (t_addr[1]),
        .i_m0_wdata  (t_wdata[0]),
        .i_m1_wdata  (t_wdata[1]),
        .i_m0_be     (t_be[0]),
        .i_m1_be     (t_be[1]),
        .o_m0_gnt    (o_m0_gnt),
        .o_m1_gnt    (o_m1_gnt),
        .o_m0_rvalid (o_m0_rvalid),
        .o_m1_rvalid (o_m1_rvalid),
        .o_m0_rdata  (o_m0_rdata),
        .o_m1_rdata  (o_m1_rdata),
        .o_mem_we    (o_mem_we),
        .o_mem_re    (o_mem_re),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_be    (o_mem_be),
        .i_mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] patt(input logic [31:0] addr);
        return 32'hA5A5_0000 | {16'h0, addr[15:0]};
    endfunction

    // Synchronous-read slave: fills itself on the first clock edge.
    logic [31:0] slave_mem [256];
    logic        slave_ready = 1'b0;
    always @(posedge i_clock) begin
        if (!slave_ready) begin
            for (int i = 0; i < 256; i++) slave_mem[i] <= patt(32'(i) << 2);
            slave_ready <= 1'b1;
        end else begin
            if (o_mem_re) mem_rdata <= slave_mem[o_mem_addr[9:2]];
            if (o_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (o_mem_be[b]) slave_mem[o_mem_addr[9:2]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [2:0]  c0;     // {req, we, lock}
        logic [31:0] a0, d0;
        logic [3:0]  b0;
        logic [2:0]  c1;
        logic [31:0] a1;
        logic [3:0]  grv;    // {gnt0, gnt1, rvalid0, rvalid1}
        logic [1:0]  wr;     // {mem_we, mem_re}
        logic [31:0] maddr, mwd;
        logic [3:0]  mbe;
    } vec_t;

    vec_t tv [NV];

    function automatic vec_t mk(input logic [2:0] c0, input logic [31:0] a0, d0, input logic [3:0] b0,
                                input logic [2:0] c1, input logic [31:0] a1, input logic [3:0] grv,
                                input logic [1:0] wr, input logic [31:0] maddr, mwd, input logic [3:0] mbe);
        vec_t v;
        v.c0 = c0; v.a0 = a0; v.d0 = d0; v.b0 = b0; v.c1 = c1; v.a1 = a1;
        v.grv = grv; v.wr = wr; v.maddr = maddr; v.mwd = mwd; v.mbe = mbe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic set_m(input int m, input logic r, w, l, input logic [31:0] a, d, input logic [3:0] b);
        t_req[m] = r; t_we[m] = w; t_lock[m] = l;
        t_addr[m] = a; t_wdata[m] = d; t_be[m] = b;
    endtask

    task automatic chk_strobes_idle(input string tag);
        chk({tag, " gnt0"}, 32'(o_m0_gnt), 32'h0);
        chk({tag, " gnt1"}, 32'(o_m1_gnt), 32'h0);
        chk({tag, " rvalid0"}, 32'(o_m0_rvalid), 32'h0);
        chk({tag, " rvalid1"}, 32'(o_m1_rvalid), 32'h0);
        chk({tag, " mem_we"}, 32'(o_mem_we), 32'h0);
        chk({tag, " mem_re"}, 32'(o_mem_re), 32'h0);
        chk({tag, " mem_addr"}, o_mem_addr, 32'h0);
    endtask

    // Behavioural model state
    int          m_last, m_owner, m_cnt, m_rd;
    logic [31:0] m_rd_data;
    logic [31:0] ref_mem [256];
    int          hold [2];

    localparam logic [2:0] I  = 3'b000;
    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] RL = 3'b101;
    localparam logic [2:0] W  = 3'b110;
    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0180;
    localparam logic [31:0] Z  = 32'h0;

    initial begin
        logic [31:0] prev_rd_addr;
        int          w;
        logic [7:0]  idx;

        tv[0]  = mk(R,  A0, Z, 4'hF, I,  Z,  4'b1000, 2'b01, A0, Z, 4'hF);
        tv[1]  = mk(I,  Z,  Z, 4'h0, R,  A1, 4'b0110, 2'b01, A1, Z, 4'hF);
        tv[2]  = mk(R,  A0, Z, 4'hF, R,  A1, 4'b1001, 2'b01, A0, Z, 4'hF);
        tv[3]  = mk(R,  A0, Z, 4'hF, R,  A1, 4'b0110, 2'b01, A1, Z, 4'hF);
        tv[4]  = mk(R,  A0, Z, 4'hF, R,  A1, 4'b1001, 2'b01, A0, Z, 4'hF);
        tv[5]  = mk(R,  A0, Z, 4'hF, R,  A1, 4'b0110, 2'b01, A1, Z, 4'hF);
        tv[6]  = mk(R,  A0, Z, 4'hF, R,  A1, 4'b1001, 2'b01, A0, Z, 4'hF);
        tv[7]  = mk(R,  A0, Z, 4'hF, R,  A1, 4'b0110, 2'b01, A1, Z, 4'hF);
        tv[8]  = mk(I,  Z,  Z, 4'h0, I,  Z,  4'b0001, 2'b00, Z,  Z, 4'h0);
        tv[9]  = mk(I,  Z,  Z, 4'h0, RL, A1, 4'b0100, 2'b01, A1, Z, 4'hF);
        tv[10] = mk(R,  A0, Z, 4'hF, RL, A1, 4'b0101, 2'b01, A1, Z, 4'hF);
        tv[11] = mk(R,  A0, Z, 4'hF, RL, A1, 4'b0101, 2'b01, A1, Z, 4'hF);
        tv[12] = mk(R,  A0, Z, 4'hF, RL, A1, 4'b0101, 2'b01, A1, Z, 4'hF);
        tv[13] = mk(R,  A0, Z, 4'hF, RL, A1, 4'b1001, 2'b01, A0, Z, 4'hF);
        tv[14] = mk(I,  Z,  Z, 4'h0, I,  Z,  4'b0010, 2'b00, Z,  Z, 4'h0);
        tv[15] = mk(I,  Z,  Z, 4'h0, R,  A1, 4'b0100, 2'b01, A1, Z, 4'hF);
        tv[16] = mk(W,  32'h200, 32'hDEADBEEF, 4'b0011, R, A1, 4'b1001, 2'b10, 32'h200, 32'hDEADBEEF, 4'b0011);
        tv[17] = mk(I,  Z,  Z, 4'h0, R,  A1, 4'b0100, 2'b01, A1, Z, 4'hF);
        tv[18] = mk(I,  Z,  Z, 4'h0, I,  Z,  4'b0001, 2'b00, Z,  Z, 4'h0);

        for (int i = 0; i < 256; i++) ref_mem[i] = patt(32'(i) << 2);

        // Reset held with a request pending: nothing may be granted.
        i_reset = 1'b0;
        set_m(0, 1'b1, 1'b0, 1'b0, A0, Z, 4'hF);
        set_m(1, 1'b1, 1'b0, 1'b0, A1, Z, 4'hF);
        repeat (2) @(negedge i_clock);
        #1;
        chk_strobes_idle("reset");
        @(negedge i_clock);
        i_reset = 1'b1;
        set_m(0, 1'b0, 1'b0, 1'b0, Z, Z, 4'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, Z, Z, 4'h0);

        prev_rd_addr = Z;
        for (int n = 0; n < NV; n++) begin
            @(negedge i_clock);
            set_m(0, tv[n].c0[2], tv[n].c0[1], tv[n].c0[0], tv[n].a0, tv[n].d0, tv[n].b0);
            set_m(1, tv[n].c1[2], tv[n].c1[1], tv[n].c1[0], tv[n].a1, Z, 4'hF);
            #1;
            chk($sformatf("v%0d gnt0", n), 32'(o_m0_gnt), 32'(tv[n].grv[3]));
            chk($sformatf("v%0d gnt1", n), 32'(o_m1_gnt), 32'(tv[n].grv[2]));
            chk($sformatf("v%0d rvalid0", n), 32'(o_m0_rvalid), 32'(tv[n].grv[1]));
            chk($sformatf("v%0d rvalid1", n), 32'(o_m1_rvalid), 32'(tv[n].grv[0]));
            chk($sformatf("v%0d mem_we", n), 32'(o_mem_we), 32'(tv[n].wr[1]));
            chk($sformatf("v%0d mem_re", n), 32'(o_mem_re), 32'(tv[n].wr[0]));
            chk($sformatf("v%0d mem_addr", n), o_mem_addr, tv[n].maddr);
            chk($sformatf("v%0d mem_wdata", n), o_mem_wdata, tv[n].mwd);
            chk($sformatf("v%0d mem_be", n), 32'(o_mem_be), 32'(tv[n].mbe));
            if (tv[n].grv[1]) chk($sformatf("v%0d rdata0", n), o_m0_rdata, patt(prev_rd_addr));
            if (tv[n].grv[0]) chk($sformatf("v%0d rdata1", n), o_m1_rdata, patt(prev_rd_addr));
            if (tv[n].wr[0]) prev_rd_addr = tv[n].maddr;
            $display("vec %0d: gnt=%b%b rvalid=%b%b we=%b re=%b addr=%08h", n,
                     o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_mem_we, o_mem_re, o_mem_addr);
        end
        ref_mem[8'h80] = 32'hA5A5_BEEF;

        // Uncontested lock for 20 cycles must not consume any of the lock budget.
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clock);
            set_m(0, 1'b1, 1'b0, 1'b1, 32'h40, Z, 4'hF);
            set_m(1, 1'b0, 1'b0, 1'b0, Z, Z, 4'h0);
            #1;
            chk($sformatf("solo lock %0d gnt0", k), 32'(o_m0_gnt), 32'h1);
            chk($sformatf("solo lock %0d gnt1", k), 32'(o_m1_gnt), 32'h0);
        end
        for (int k = 0; k < MAXL + 1; k++) begin
            @(negedge i_clock);
            set_m(0, 1'b1, 1'b0, 1'b1, 32'h40, Z, 4'hF);
            set_m(1, 1'b1, 1'b0, 1'b0, A1, Z, 4'hF);
            #1;
            chk($sformatf("contended lock %0d gnt0", k), 32'(o_m0_gnt), 32'(k < MAXL));
            chk($sformatf("contended lock %0d gnt1", k), 32'(o_m1_gnt), 32'(k == MAXL));
            $display("lock step %0d: gnt=%b%b", k, o_m0_gnt, o_m1_gnt);
        end

        // Read granted, then reset lands before its data would return.
        @(negedge i_clock);
        set_m(0, 1'b1, 1'b0, 1'b0, A0, Z, 4'hF);
        set_m(1, 1'b0, 1'b0, 1'b0, Z, Z, 4'h0);
        #1;
        chk("pre-reset read gnt0", 32'(o_m0_gnt), 32'h1);
        #1 i_reset = 1'b0;
        @(negedge i_clock);
        set_m(1, 1'b1, 1'b0, 1'b0, A1, Z, 4'hF);
        #1;
        chk_strobes_idle("mid reset");
        @(negedge i_clock);
        i_reset = 1'b1;
        #1;
        chk("post reset rvalid0", 32'(o_m0_rvalid), 32'h0);
        chk("post reset gnt0", 32'(o_m0_gnt), 32'h1);
        chk("post reset gnt1", 32'(o_m1_gnt), 32'h0);
        $display("reset seq: first contention gnt=%b%b", o_m0_gnt, o_m1_gnt);

        // Randomized traffic against the model, from a fresh reset.
        @(negedge i_clock);
        i_reset = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, Z, Z, 4'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, Z, Z, 4'h0);
        @(negedge i_clock);
        i_reset = 1'b1;
        m_last = 1; m_owner = -1; m_cnt = 0; m_rd = -1; m_rd_data = Z;
        hold[0] = 0; hold[1] = 0;

        for (int c = 0; c < 800; c++) begin
            @(negedge i_clock);
            for (int m = 0; m < 2; m++) begin
                if (hold[m] == 0) begin
                    if ($urandom_range(0, 3) != 0)
                        set_m(m, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 4'($urandom_range(0, 15)));
                    else
                        set_m(m, 1'b0, 1'b0, 1'b0, Z, Z, 4'h0);
                end
            end
            #1;
            if (t_req == 2'b01)      w = 0;
            else if (t_req == 2'b10) w = 1;
            else if (t_req == 2'b11) w = (m_owner >= 0 && m_cnt < MAXL) ? m_owner : 1 - m_last;
            else                     w = -1;

            chk($sformatf("r%0d gnt0", c), 32'(o_m0_gnt), 32'(w == 0));
            chk($sformatf("r%0d gnt1", c), 32'(o_m1_gnt), 32'(w == 1));
            chk($sformatf("r%0d mem_we", c), 32'(o_mem_we), 32'(w >= 0 && t_we[w]));
            chk($sformatf("r%0d mem_re", c), 32'(o_mem_re), 32'(w >= 0 && !t_we[w]));
            chk($sformatf("r%0d mem_addr", c), o_mem_addr, (w >= 0) ? t_addr[w] : Z);
            chk($sformatf("r%0d mem_wdata", c), o_mem_wdata, (w >= 0) ? t_wdata[w] : Z);
            chk($sformatf("r%0d mem_be", c), 32'(o_mem_be), (w >= 0) ? 32'(t_be[w]) : Z);
            chk($sformatf("r%0d rvalid0", c), 32'(o_m0_rvalid), 32'(m_rd == 0));
            chk($sformatf("r%0d rvalid1", c), 32'(o_m1_rvalid), 32'(m_rd == 1));
            if (m_rd == 0) chk($sformatf("r%0d rdata0", c), o_m0_rdata, m_rd_data);
            if (m_rd == 1) chk($sformatf("r%0d rdata1", c), o_m1_rdata, m_rd_data);
            if (w >= 0)
                $display("rnd %0d: m%0d %s addr=%08h lock=%b", c, w, t_we[w] ? "wr" : "rd", t_addr[w], t_lock[w]);

            // Advance the model by one clock edge.
            if (m_owner < 0) begin
                if (w >= 0 && t_lock[w]) m_owner = w;
            end else if (w == m_owner && t_lock[w]) begin
                if (t_req[1 - w] && m_cnt < MAXL) m_cnt++;
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
            m_rd = -1;
            if (w >= 0) begin
                m_last = w;
                idx    = t_addr[w][9:2];
                if (!t_we[w]) begin
                    m_rd      = w;
                    m_rd_data = ref_mem[idx];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (t_be[w][b]) ref_mem[idx][8*b +: 8] = t_wdata[w][8*b +: 8];
                end
            end
            for (int m = 0; m < 2; m++) hold[m] = (t_req[m] && w != m) ? 1 : 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared data-memory port.
- Master 0 is the processor data port; master 1 is a secondary requester (DMA or debug loader).
- One access per cycle reaches the slave. Read data returns one cycle after grant (synchronous-read data memory).
- Round-robin fairness, plus an optional bounded lock for atomic/burst sequences.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data width; byte-enable width = DATA_WIDTH/8.
- MAX_LOCK, 8, maximum consecutive grants a locking master may hold while the other master is requesting; range 1..255.

Ports:
- i_clock  in  1  system clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_m0_req, i_m1_req  in  1  access request; held until the grant cycle.
- i_m0_we, i_m1_we  in  1  1=write, 0=read.
- i_m0_lock, i_m1_lock  in  1  request to keep ownership next cycle.
- i_m0_addr, i_m1_addr  in  ADDR_WIDTH  byte address.
- i_m0_wdata, i_m1_wdata  in  DATA_WIDTH  write data.
- i_m0_be, i_m1_be  in  DATA_WIDTH/8  byte enables.
- o_m0_gnt, o_m1_gnt  out  1  access accepted this cycle (combinational).
- o_m0_rvalid, o_m1_rvalid  out  1  read data valid (registered).
- o_m0_rdata, o_m1_rdata  out  DATA_WIDTH  read data; both driven from slave data.
- o_mem_we, o_mem_re  out  1  slave write/read strobe (combinational).
- o_mem_addr  out  ADDR_WIDTH  slave address.
- o_mem_wdata  out  DATA_WIDTH  slave write data.
- o_mem_be  out  DATA_WIDTH/8  slave byte enables.
- i_mem_rdata  in  DATA_WIDTH  slave read data, valid the cycle after o_mem_re.

Behaviour:
- State registers:
  - last_q: last winner, reset 1, so M0 wins the first contention.
  - owner_q: locked owner, 2-bit {NONE, M0, M1}, reset NONE.
  - lock_cnt_q: 8 bits, reset 0.
  - rd_owner_q: 2 bits, reset NONE.
- Reset values: all o_*_gnt, o_*_rvalid, o_mem_we and o_mem_re are 0 during reset. o_*_rdata pass i_mem_rdata. Address, data and byte-enable outputs are 0 when no grant is asserted.
- Arbitration, evaluated each cycle:
  - Only one master requesting: that master wins.
  - Both requesting and owner_q==Mx with lock_cnt_q<MAX_LOCK: Mx wins.
  - Otherwise, on contention, the master != last_q wins.
- Grant: winner's gnt=1. Slave outputs are muxed from the winner. o_mem_we=winner.we; o_mem_re=~winner.we.
- Grant bookkeeping: last_q<=winner on every grant. No grant leaves last_q unchanged.
- Lock FSM:
  - NONE -> Mx when Mx granted with lock=1.
  - Mx stays Mx while Mx is granted with lock=1 and lock_cnt_q<MAX_LOCK.
  - Mx -> NONE on any of: a grant with lock=0; a cycle where Mx does not request; lock_cnt_q reaching MAX_LOCK with the other master requesting, in which case the other master wins that cycle.
  - lock_cnt_q increments only on cycles where owner_q holds the grant against a competing request. It saturates at MAX_LOCK and clears on any transition to NONE.
  - A lock with no contender never expires.
- Read return:
  - rd_owner_q<=winner when a read is granted, else NONE.
  - o_mx_rvalid = (rd_owner_q==Mx). Latency is exactly 1 cycle.
  - Back-to-back reads from alternating masters return in grant order without bubbles.
- Writes produce no rvalid. A write and the next cycle's rvalid of a prior read may coexist.
- Simultaneous grant and rvalid to the same master is legal (pipelined reads).
- Reset mid-read: rd_owner_q clears and the pending rvalid is dropped. Masters must reissue after reset.
- A master must hold addr/we/wdata/be stable while req=1 and gnt=0.

Decomposition:
- Package DataBusDefs:
  - master_id_t enum {MST_NONE, MST_0, MST_1};
  - DATA_BUS_LOCK_W = 8;
  - a typedef'd request struct (we, lock, addr, wdata, be) shared with the DMA block.
- Sub-module rr_arbiter2: pure winner selection (req[1:0], last, owner, lock_expired -> winner). Enables exhaustive stand-alone checking.
- The top holds the registers and muxes.

Test Plan:
- Reset release, M0 reads 0x0100 alone -> o_m0_gnt=1 same cycle; o_m0_rvalid=1 next cycle with memory word; o_m1_* idle.
- Both masters request reads every cycle for 6 cycles -> grants alternate M0,M1,M0,M1,M0,M1; rvalid follows each grant by 1 cycle to the correct master.
- M1 lock=1 and M0 continuously requesting, MAX_LOCK=3 -> M1 granted 3 consecutive cycles, M0 on the 4th, owner_q=NONE afterwards.
- M0 locks with M1 idle for 20 cycles -> M0 granted all 20; lock_cnt_q stays 0.
- M0 writes 0xDEADBEEF be=4'b0011 to 0x0200 while M1 requested the previous cycle -> o_mem_we=1, o_mem_be=0011; no rvalid; M1 served next cycle.
- Read granted, i_reset low for 1 cycle before rvalid -> no rvalid asserted; all strobes 0 during reset; M0 wins the first post-reset contention.
